// File: rtl/sha256_pkg.sv
// Shared register map, response codes and sizing for the SHA-256 AXI4-Lite message loader.
package sha256_pkg;

   typedef enum logic [1:0] {
      REG_CTRL   = 2'd0,
      REG_STATUS = 2'd1,
      REG_DATA   = 2'd2,
      REG_DIGEST = 2'd3
   } reg_e;

   localparam int CTRL_INIT  = 0;
   localparam int CTRL_LAST  = 1;
   localparam int CTRL_CLEAR = 2;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int BLOCK_WORDS  = 16;
   localparam int DIGEST_WORDS = 8;

endpackage

// File: rtl/sha256_axil_if.sv
// AXI4-Lite handshake engine: one write and one read outstanding, ready pulses one cycle after valid,
// responses registered and held until the master takes them.
module sha256_axil_if
   import sha256_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        awvalid_i,
   input  logic        wvalid_i,
   output logic        awready_o,
   output logic        wready_o,
   input  logic [1:0]  waddr_i,
   input  logic [31:0] wdata_i,
   output logic [1:0]  bresp_o,
   output logic        bvalid_o,
   input  logic        bready_i,
   input  logic        arvalid_i,
   output logic        arready_o,
   input  logic [1:0]  araddr_i,
   output logic [31:0] rdata_o,
   output logic [1:0]  rresp_o,
   output logic        rvalid_o,
   input  logic        rready_i,
   output logic        wr_en_o,
   output reg_e        wr_addr_o,
   output logic [31:0] wr_data_o,
   input  logic        wr_err_i,
   output logic        rd_en_o,
   output reg_e        rd_addr_o,
   input  logic [31:0] rd_data_i
);

   logic        aw_rdy_q;
   logic        ar_rdy_q;
   logic        bvalid_q;
   logic        rvalid_q;
   logic [1:0]  bresp_q;
   logic [31:0] rdata_q;

   assign wr_en_o   = aw_rdy_q & awvalid_i & wvalid_i;
   assign wr_addr_o = reg_e'(waddr_i);
   assign wr_data_o = wdata_i;
   assign rd_en_o   = ar_rdy_q & arvalid_i;
   assign rd_addr_o = reg_e'(araddr_i);

   assign awready_o = aw_rdy_q;
   assign wready_o  = aw_rdy_q;
   assign bvalid_o  = bvalid_q;
   assign bresp_o   = bresp_q;
   assign arready_o = ar_rdy_q;
   assign rvalid_o  = rvalid_q;
   assign rdata_o   = rdata_q;
   assign rresp_o   = RESP_OKAY;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         aw_rdy_q <= 1'b0;
         ar_rdy_q <= 1'b0;
         bvalid_q <= 1'b0;
         rvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
         rdata_q  <= '0;
      end else begin
         // Self-gating on the ready flop keeps the pulse to exactly one cycle.
         aw_rdy_q <= awvalid_i & wvalid_i & ~bvalid_q & ~aw_rdy_q;
         ar_rdy_q <= arvalid_i & ~rvalid_q & ~ar_rdy_q;

         if (wr_en_o) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_err_i ? RESP_SLVERR : RESP_OKAY;
         end else if (bvalid_q && bready_i) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
         end

         if (rd_en_o) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data_i;
         end else if (rvalid_q && rready_i) begin
            rvalid_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/sha256_axil_msg_loader.sv
// Packs software-written words into 512-bit blocks for the hash core and serves the captured digest.
// Block is offered one cycle after the 16th word; further DATA writes are dropped with SLVERR until it is taken.
module sha256_axil_msg_loader #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int BLOCK_WORDS        = 16,
   parameter int DIGEST_WORDS       = 8
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [32*BLOCK_WORDS-1:0]       blk_data,
   output logic                            blk_first,
   output logic                            blk_last,
   output logic                            blk_valid,
   input  logic                            blk_ready,
   input  logic [32*DIGEST_WORDS-1:0]      dig_data,
   input  logic                            dig_valid
);
   import sha256_pkg::*;

   localparam int CW = $clog2(BLOCK_WORDS + 1);
   localparam int IW = $clog2(BLOCK_WORDS);
   localparam int PW = $clog2(DIGEST_WORDS);
   localparam logic [CW-1:0] FULL_CNT = CW'(BLOCK_WORDS);

   logic        wr_en, rd_en, wr_err;
   reg_e        wr_addr, rd_addr;
   logic [31:0] wr_data, rd_data;

   logic [31:0]   words_q [BLOCK_WORDS];
   logic [31:0]   dig_q   [DIGEST_WORDS];
   logic [CW-1:0] cnt_q;
   logic [PW-1:0] ptr_q;
   logic [31:0]   last_data_q;
   logic          blk_valid_q, blk_first_q, blk_last_q;
   logic          init_flag_q, last_flag_q, ovf_q, dig_valid_q;

   logic          hs, full, data_wr, data_store, ctrl_wr;
   logic [CW-1:0] eff_cnt;

   logic unused_ok;
   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB,
                        S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   sha256_axil_if u_if (
      .clk_i     (ACLK),
      .rst_ni    (ARESETN),
      .awvalid_i (S_AXI_AWVALID),
      .wvalid_i  (S_AXI_WVALID),
      .awready_o (S_AXI_AWREADY),
      .wready_o  (S_AXI_WREADY),
      .waddr_i   (S_AXI_AWADDR[3:2]),
      .wdata_i   (S_AXI_WDATA),
      .bresp_o   (S_AXI_BRESP),
      .bvalid_o  (S_AXI_BVALID),
      .bready_i  (S_AXI_BREADY),
      .arvalid_i (S_AXI_ARVALID),
      .arready_o (S_AXI_ARREADY),
      .araddr_i  (S_AXI_ARADDR[3:2]),
      .rdata_o   (S_AXI_RDATA),
      .rresp_o   (S_AXI_RRESP),
      .rvalid_o  (S_AXI_RVALID),
      .rready_i  (S_AXI_RREADY),
      .wr_en_o   (wr_en),
      .wr_addr_o (wr_addr),
      .wr_data_o (wr_data),
      .wr_err_i  (wr_err),
      .rd_en_o   (rd_en),
      .rd_addr_o (rd_addr),
      .rd_data_i (rd_data)
   );

   // A block being consumed this edge frees the buffer for a coincident DATA write.
   assign hs         = blk_valid_q & blk_ready;
   assign eff_cnt    = hs ? '0 : cnt_q;
   assign full       = (blk_valid_q & ~blk_ready) | (~blk_valid_q & (cnt_q == FULL_CNT));
   assign data_wr    = wr_en & (wr_addr == REG_DATA);
   assign data_store = data_wr & ~full;
   assign wr_err     = data_wr & full;
   assign ctrl_wr    = wr_en & (wr_addr == REG_CTRL);

   assign blk_valid = blk_valid_q;
   assign blk_first = blk_first_q;
   assign blk_last  = blk_last_q;

   always_comb begin
      blk_data = '0;
      for (int i = 0; i < BLOCK_WORDS; i++)
         blk_data[32*BLOCK_WORDS-1-32*i -: 32] = words_q[i];
   end

   always_comb begin
      rd_data = '0;
      case (rd_addr)
         REG_STATUS: rd_data = {{(28-CW){1'b0}}, cnt_q, 1'b0, ovf_q, dig_valid_q, blk_valid_q};
         REG_DATA:   rd_data = last_data_q;
         REG_DIGEST: rd_data = dig_q[ptr_q];
         default:    rd_data = '0;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int i = 0; i < BLOCK_WORDS; i++) words_q[i] <= '0;
         for (int i = 0; i < DIGEST_WORDS; i++) dig_q[i] <= '0;
         cnt_q       <= '0;
         ptr_q       <= '0;
         last_data_q <= '0;
         blk_valid_q <= 1'b0;
         blk_first_q <= 1'b0;
         blk_last_q  <= 1'b0;
         init_flag_q <= 1'b0;
         last_flag_q <= 1'b0;
         ovf_q       <= 1'b0;
         dig_valid_q <= 1'b0;
      end else begin
         if (hs) begin
            blk_valid_q <= 1'b0;
            cnt_q       <= '0;
         end else if (!blk_valid_q && cnt_q == FULL_CNT) begin
            blk_valid_q <= 1'b1;
            blk_first_q <= init_flag_q;
            blk_last_q  <= last_flag_q;
            init_flag_q <= 1'b0;
            last_flag_q <= 1'b0;
         end

         if (data_store) begin
            words_q[eff_cnt[IW-1:0]] <= wr_data;
            cnt_q                    <= eff_cnt + 1'b1;
            last_data_q              <= wr_data;
         end
         if (wr_err) ovf_q <= 1'b1;

         if (rd_en && rd_addr == REG_DIGEST) ptr_q <= ptr_q + 1'b1;

         if (ctrl_wr) begin
            if (wr_data[CTRL_INIT]) begin
               init_flag_q <= 1'b1;
               dig_valid_q <= 1'b0;
               ptr_q       <= '0;
            end
            if (wr_data[CTRL_LAST]) last_flag_q <= 1'b1;
            if (wr_data[CTRL_CLEAR]) begin
               cnt_q       <= '0;
               ovf_q       <= 1'b0;
               blk_valid_q <= 1'b0;
            end
         end

         // Capture overrides INIT and any DIGEST read pointer advance.
         if (dig_valid) begin
            for (int i = 0; i < DIGEST_WORDS; i++)
               dig_q[i] <= dig_data[32*DIGEST_WORDS-1-32*i -: 32];
            dig_valid_q <= 1'b1;
            ptr_q       <= '0;
         end
      end
   end

endmodule
